vx_gpr_writeback: RTL and testbench

//  Write side of the per-slice GPR protocol: collects commit packets from the execution units and drives the

---
 rtl/vx_gpr_writeback_pkg.sv | 56 +++++
 rtl/vx_gpr_writeback_lock_arb.sv | 81 ++++++++
 rtl/vx_gpr_writeback.sv | 88 ++++++++
 tb/tb_vx_gpr_writeback.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_gpr_writeback_pkg.sv
// Commit/writeback packet layouts and field widths shared by the GPR writeback path.
package vx_gpr_writeback_pkg;

   localparam int unsigned UUID_WIDTH    = 8;
   localparam int unsigned ISSUE_WIS_W   = 2;
   localparam int unsigned NUM_THREADS   = 4;
   localparam int unsigned PC_BITS       = 16;
   localparam int unsigned NR_BITS       = 5;
   localparam int unsigned XLEN          = 32;
   localparam int unsigned PERF_CTR_BITS = 16;

   typedef struct packed {
      logic [UUID_WIDTH-1:0]       uuid;
      logic [ISSUE_WIS_W-1:0]      wis;
      logic [NUM_THREADS-1:0]      tmask;
      logic [PC_BITS-1:0]          pc;
      logic                        wb;
      logic [NR_BITS-1:0]          rd;
      logic [NUM_THREADS*XLEN-1:0] data;
      logic                        sop;
      logic                        eop;
   } commit_t;

   typedef struct packed {
      logic [UUID_WIDTH-1:0]       uuid;
      logic [ISSUE_WIS_W-1:0]      wis;
      logic [NUM_THREADS-1:0]      tmask;
      logic [PC_BITS-1:0]          pc;
      logic [NR_BITS-1:0]          rd;
      logic [NUM_THREADS*XLEN-1:0] data;
      logic                        sop;
      logic                        eop;
   } wb_t;

   localparam int unsigned COMMIT_DATAW = $bits(commit_t);
   localparam int unsigned WB_DATAW     = $bits(wb_t);

   // r0 is hardwired and an empty thread mask writes nothing.
   function automatic logic is_write(commit_t c);
      return c.wb && (c.rd != '0) && (c.tmask != '0);
   endfunction

   function automatic wb_t to_wb(commit_t c);
      wb_t w;
      w.uuid  = c.uuid;
      w.wis   = c.wis;
      w.tmask = c.tmask;
      w.pc    = c.pc;
      w.rd    = c.rd;
      w.data  = c.data;
      w.sop   = c.sop;
      w.eop   = c.eop;
      return w;
   endfunction

endpackage

// File: rtl/vx_gpr_writeback_lock_arb.sv
// Round-robin arbiter that locks onto one input from sop to eop so multi-beat sequences stay whole.
module vx_gpr_writeback_lock_arb #(
   parameter int unsigned NUM_INPUTS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_INPUTS-1:0] valid,
   input  logic [NUM_INPUTS-1:0] sop,
   input  logic [NUM_INPUTS-1:0] eop,
   output logic [NUM_INPUTS-1:0] grant
);

   if (NUM_INPUTS == 1) begin : g_single
      logic unused_arb;
      assign unused_arb = ^{clk, sop, eop};
      assign grant      = valid & reset_n;
   end else begin : g_rr
      localparam int unsigned IdxW = $clog2(NUM_INPUTS);
      localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_INPUTS - 1);

      logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
      logic [IdxW-1:0] lock_id_q, lock_id_d;
      logic            lock_q, lock_d;
      logic [IdxW-1:0] gnt_idx;
      logic            gnt_any;
      int unsigned     idx;

      always_comb begin
         gnt_any = 1'b0;
         gnt_idx = '0;
         idx     = 0;
         if (lock_q) begin
            gnt_any = valid[lock_id_q];
            gnt_idx = lock_id_q;
         end else begin
            for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
               idx = (int'(rr_ptr_q) + k) % NUM_INPUTS;
               if (!gnt_any && valid[idx]) begin
                  gnt_any = 1'b1;
                  gnt_idx = idx[IdxW-1:0];
               end
            end
         end
      end

      // Ready must drop the moment reset asserts, even with valids still high.
      always_comb begin
         grant = '0;
         if (gnt_any && reset_n) grant[gnt_idx] = 1'b1;
      end

      always_comb begin
         lock_d    = lock_q;
         lock_id_d = lock_id_q;
         rr_ptr_d  = rr_ptr_q;
         if (gnt_any) begin
            if (sop[gnt_idx] && !eop[gnt_idx]) begin
               lock_d    = 1'b1;
               lock_id_d = gnt_idx;
            end else if (eop[gnt_idx]) begin
               lock_d   = 1'b0;
               // The finishing unit becomes lowest priority next cycle.
               rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
         end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
         end
      end
   end

endmodule

// File: rtl/vx_gpr_writeback.sv
// GPR writeback: arbitrates commit packets from execution units onto a registered single-beat
// writeback bus, dropping packets that write nothing.
module vx_gpr_writeback
   import vx_gpr_writeback_pkg::*;
#(
   parameter int unsigned NUM_INPUTS  = 4,
   parameter int unsigned PERF_ENABLE = 0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_INPUTS-1:0]            commit_valid,
   output logic [NUM_INPUTS-1:0]            commit_ready,
   input  logic [NUM_INPUTS*COMMIT_DATAW-1:0] commit_data,
   output logic                             wb_valid,
   output logic [WB_DATAW-1:0]              wb_data,
   output logic [PERF_CTR_BITS-1:0]         perf_writes,
   output logic [PERF_CTR_BITS-1:0]         perf_stalls
);

   commit_t               pkts [NUM_INPUTS];
   commit_t               sel;
   logic [NUM_INPUTS-1:0] sop, eop;
   logic                  wb_fire;
   logic                  wb_valid_q;
   wb_t                   wb_data_q;

   always_comb begin
      sel = '0;
      sop = '0;
      eop = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         pkts[i] = commit_t'(commit_data[i*COMMIT_DATAW +: COMMIT_DATAW]);
         sop[i]  = pkts[i].sop;
         eop[i]  = pkts[i].eop;
         if (commit_ready[i]) sel = commit_t'(sel | pkts[i]);
      end
   end

   vx_gpr_writeback_lock_arb #(
      .NUM_INPUTS (NUM_INPUTS)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .valid   (commit_valid),
      .sop     (sop),
      .eop     (eop),
      .grant   (commit_ready)
   );

   assign wb_fire = (|commit_ready) && is_write(sel);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= wb_fire;
         if (wb_fire) wb_data_q <= to_wb(sel);
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_data  = wb_data_q;

   if (PERF_ENABLE != 0) begin : g_perf
      logic [PERF_CTR_BITS-1:0] writes_q, stalls_q;
      logic                     stall;

      assign stall = |(commit_valid & ~commit_ready);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            writes_q <= '0;
            stalls_q <= '0;
         end else begin
            if (wb_valid_q) writes_q <= writes_q + 1'b1;
            if (stall)      stalls_q <= stalls_q + 1'b1;
         end
      end

      assign perf_writes = writes_q;
      assign perf_stalls = stalls_q;
   end else begin : g_no_perf
      assign perf_writes = '0;
      assign perf_stalls = '0;
   end

endmodule

// File: tb/tb_vx_gpr_writeback.sv
// Directed self-checking bench for vx_gpr_writeback with four commit sources and perf counters on.
module tb_vx_gpr_writeback;
   import vx_gpr_writeback_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = COMMIT_DATAW;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [N-1:0]             commit_valid;
   logic [N-1:0]             commit_ready;
   logic [N*CW-1:0]          commit_data;
   logic                     wb_valid;
   logic [WB_DATAW-1:0]      wb_data;
   logic [PERF_CTR_BITS-1:0] perf_writes;
   logic [PERF_CTR_BITS-1:0] perf_stalls;

   int checks = 0;
   int errors = 0;
   int exp_writes = 0;
   wb_t last_exp;

   always #5 clk = ~clk;

   vx_gpr_writeback #(
      .NUM_INPUTS  (N),
      .PERF_ENABLE (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .commit_valid (commit_valid),
      .commit_ready (commit_ready),
      .commit_data  (commit_data),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .perf_writes  (perf_writes),
      .perf_stalls  (perf_stalls)
   );

   function automatic commit_t mk(logic [7:0] uuid, logic [1:0] wis, logic [3:0] tmask, logic wb,
                                  logic [4:0] rd, logic sop, logic eop);
      commit_t c;
      c.uuid  = uuid;
      c.wis   = wis;
      c.tmask = tmask;
      c.pc    = 16'h2000 + {8'h00, uuid};
      c.wb    = wb;
      c.rd    = rd;
      c.data  = {4{24'hC0FFEE, uuid}};
      c.sop   = sop;
      c.eop   = eop;
      return c;
   endfunction

   function automatic wb_t exp_of(commit_t c);
      wb_t w;
      w.uuid  = c.uuid;
      w.wis   = c.wis;
      w.tmask = c.tmask;
      w.pc    = c.pc;
      w.rd    = c.rd;
      w.data  = c.data;
      w.sop   = c.sop;
      w.eop   = c.eop;
      return w;
   endfunction

   task automatic drive(int u, commit_t p);
      commit_valid[u]            = 1'b1;
      commit_data[u*CW +: CW]    = p;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; commit_valid = '0; commit_data = '0;
      step(); step();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
      checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
      reset_n = 1'b1;
      drive(0, mk(8'h01, 2'd0, 4'hF, 1'b1, 5'd3, 1'b1, 1'b1));
      drive(1, mk(8'h02, 2'd0, 4'hF, 1'b1, 5'd4, 1'b1, 1'b1));
      step();
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_wb_valid got %b want 1", wb_valid); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL async_reset_wb_valid got %b want 0", wb_valid); end
      checks++; if (commit_ready !== 4'b0000) begin errors++; $display("FAIL async_reset_ready got %b want 0000", commit_ready); end
      checks++; if (wb_data !== '0) begin errors++; $display("FAIL async_reset_wb_data got %h want 0", wb_data); end
      checks++; if (perf_stalls !== '0) begin errors++; $display("FAIL async_reset_stalls got %0d want 0", perf_stalls); end
      checks++; if (perf_writes !== '0) begin errors++; $display("FAIL async_reset_writes got %0d want 0", perf_writes); end
      commit_valid = '0;
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_round_robin();
      logic [PERF_CTR_BITS-1:0] s0;
      logic [N-1:0]             want;
      commit_t                  p [N];
      s0 = perf_stalls;
      for (int c = 0; c < 5; c++) begin
         for (int u = 0; u < N; u++) begin
            p[u] = mk(8'(8'h10 + c*4 + u), 2'd0, 4'hF, 1'b1, 5'(u + 1), 1'b1, 1'b1);
            drive(u, p[u]);
         end
         want = N'(1) << (c % N);
         #1;
         checks++; if (commit_ready !== want) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", c, commit_ready, want); end
         step();
         last_exp = exp_of(p[c % N]);
         exp_writes++;
         checks++; if (wb_valid !== 1'b1 || wb_data !== last_exp) begin
            errors++; $display("FAIL rr_wb[%0d] got %b/%h want 1/%h", c, wb_valid, wb_data, last_exp);
         end
      end
      commit_valid = '0;
      step(); step();
      checks++; if (perf_stalls - s0 !== 16'd5) begin errors++; $display("FAIL rr_stalls got %0d want 5", perf_stalls - s0); end
      checks++; if (perf_writes !== 16'(exp_writes)) begin errors++; $display("FAIL rr_writes got %0d want %0d", perf_writes, exp_writes); end
   endtask

   task automatic test_single();
      commit_t p;
      p = mk(8'h55, 2'd1, 4'b1011, 1'b1, 5'd5, 1'b1, 1'b1);
      drive(2, p);
      #1;
      checks++; if (commit_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", commit_ready); end
      step();
      commit_valid = '0;
      last_exp = exp_of(p);
      exp_writes++;
      checks++; if (wb_valid !== 1'b1 || wb_data !== last_exp) begin
         errors++; $display("FAIL single_wb got %b/%h want 1/%h", wb_valid, wb_data, last_exp);
      end
      step();
      checks++; if (wb_valid !== 1'b0 || wb_data !== last_exp) begin
         errors++; $display("FAIL single_hold got %b/%h want 0/%h", wb_valid, wb_data, last_exp);
      end
      step();
      checks++; if (perf_writes !== 16'(exp_writes)) begin errors++; $display("FAIL single_writes got %0d want %0d", perf_writes, exp_writes); end
   endtask

   task automatic test_lock();
      logic [PERF_CTR_BITS-1:0] s0;
      commit_t                  a, b [3], c;
      // Unit0 goes first alone so unit1 is next in round-robin order.
      a = mk(8'h60, 2'd0, 4'hF, 1'b1, 5'd9, 1'b1, 1'b1);
      drive(0, a);
      #1;
      checks++; if (commit_ready !== 4'b0001) begin errors++; $display("FAIL lock_pre_ready got %b want 0001", commit_ready); end
      step();
      exp_writes++;
      s0   = perf_stalls;
      b[0] = mk(8'h70, 2'd2, 4'hF, 1'b1, 5'd7, 1'b1, 1'b0);
      b[1] = mk(8'h71, 2'd2, 4'hF, 1'b1, 5'd7, 1'b0, 1'b0);
      b[2] = mk(8'h72, 2'd2, 4'hF, 1'b1, 5'd7, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(0, a);
         drive(1, b[k]);
         #1;
         checks++; if (commit_ready !== 4'b0010) begin errors++; $display("FAIL lock_ready[%0d] got %b want 0010", k, commit_ready); end
         step();
         last_exp = exp_of(b[k]);
         exp_writes++;
         checks++; if (wb_valid !== 1'b1 || wb_data !== last_exp) begin
            errors++; $display("FAIL lock_wb[%0d] got %b/%h want 1/%h", k, wb_valid, wb_data, last_exp);
         end
      end
      // Unit1 keeps requesting right after its eop but now ranks last.
      c = mk(8'h73, 2'd2, 4'hF, 1'b1, 5'd7, 1'b1, 1'b1);
      drive(1, c);
      #1;
      checks++; if (commit_ready !== 4'b0001) begin errors++; $display("FAIL release_ready got %b want 0001", commit_ready); end
      step();
      last_exp = exp_of(a);
      exp_writes++;
      checks++; if (wb_data !== last_exp) begin errors++; $display("FAIL release_wb got %h want %h", wb_data, last_exp); end
      commit_valid[0] = 1'b0;
      #1;
      checks++; if (commit_ready !== 4'b0010) begin errors++; $display("FAIL release_next_ready got %b want 0010", commit_ready); end
      step();
      last_exp = exp_of(c);
      exp_writes++;
      commit_valid = '0;
      step(); step();
      checks++; if (perf_stalls - s0 !== 16'd4) begin errors++; $display("FAIL lock_stalls got %0d want 4", perf_stalls - s0); end
      checks++; if (perf_writes !== 16'(exp_writes)) begin errors++; $display("FAIL lock_writes got %0d want %0d", perf_writes, exp_writes); end
   endtask

   task automatic test_drops();
      commit_t p [3];
      p[0] = mk(8'h80, 2'd3, 4'hF, 1'b1, 5'd0, 1'b1, 1'b1);
      p[1] = mk(8'h81, 2'd3, 4'hF, 1'b0, 5'd6, 1'b1, 1'b1);
      p[2] = mk(8'h82, 2'd3, 4'h0, 1'b1, 5'd6, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(3, p[k]);
         #1;
         checks++; if (commit_ready !== 4'b1000) begin errors++; $display("FAIL drop_ready[%0d] got %b want 1000", k, commit_ready); end
         step();
         checks++; if (wb_valid !== 1'b0 || wb_data !== last_exp) begin
            errors++; $display("FAIL drop_wb[%0d] got %b/%h want 0/%h", k, wb_valid, wb_data, last_exp);
         end
      end
      commit_valid = '0;
      step(); step();
      checks++; if (perf_writes !== 16'(exp_writes)) begin errors++; $display("FAIL drop_writes got %0d want %0d", perf_writes, exp_writes); end
   endtask

   task automatic test_lock_idle();
      logic [PERF_CTR_BITS-1:0] s0;
      commit_t                  h0, h1, q;
      h0 = mk(8'h90, 2'd1, 4'b0110, 1'b1, 5'd4, 1'b1, 1'b0);
      h1 = mk(8'h91, 2'd1, 4'b0110, 1'b1, 5'd4, 1'b0, 1'b1);
      q  = mk(8'h92, 2'd0, 4'b0001, 1'b1, 5'd2, 1'b1, 1'b1);
      drive(3, h0);
      #1;
      checks++; if (commit_ready !== 4'b1000) begin errors++; $display("FAIL idle_sop_ready got %b want 1000", commit_ready); end
      step();
      last_exp = exp_of(h0);
      exp_writes++;
      checks++; if (wb_valid !== 1'b1 || wb_data !== last_exp) begin
         errors++; $display("FAIL idle_sop_wb got %b/%h want 1/%h", wb_valid, wb_data, last_exp);
      end
      s0 = perf_stalls;
      commit_valid[3] = 1'b0;
      drive(1, q);
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (commit_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready[%0d] got %b want 0000", k, commit_ready); end
         step();
         checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL idle_wb[%0d] got %b want 0", k, wb_valid); end
      end
      drive(3, h1);
      #1;
      checks++; if (commit_ready !== 4'b1000) begin errors++; $display("FAIL idle_eop_ready got %b want 1000", commit_ready); end
      step();
      last_exp = exp_of(h1);
      exp_writes++;
      checks++; if (wb_valid !== 1'b1 || wb_data !== last_exp) begin
         errors++; $display("FAIL idle_eop_wb got %b/%h want 1/%h", wb_valid, wb_data, last_exp);
      end
      commit_valid[3] = 1'b0;
      #1;
      checks++; if (commit_ready !== 4'b0010) begin errors++; $display("FAIL idle_after_ready got %b want 0010", commit_ready); end
      step();
      commit_valid = '0;
      last_exp = exp_of(q);
      exp_writes++;
      checks++; if (wb_valid !== 1'b1 || wb_data !== last_exp) begin
         errors++; $display("FAIL idle_after_wb got %b/%h want 1/%h", wb_valid, wb_data, last_exp);
      end
      step(); step();
      checks++; if (perf_stalls - s0 !== 16'd5) begin errors++; $display("FAIL idle_stalls got %0d want 5", perf_stalls - s0); end
      checks++; if (perf_writes !== 16'(exp_writes)) begin errors++; $display("FAIL idle_writes got %0d want %0d", perf_writes, exp_writes); end
   endtask

   initial begin
      last_exp = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_lock();
      test_drops();
      test_lock_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
